// File: rtl/gpio_switch_input.sv
// gpio_switch_input
// Switch/button input port for the microblaze SoC, the inbound partner of the
// LED output port. Raw inputs are synchronised, debounced per bit, and rising
// edges of the debounced state are latched into a sticky capture register
// that drives a maskable, registered interrupt. The CPU sees three registers
// over a single-cycle sel/rd/wr/ack bus:
//   addr 0 : debounced state (read-only)
//   addr 1 : capture (write-1-to-clear; a new edge in the same cycle wins)
//   addr 2 : interrupt mask (read/write)
//   addr 3 : reads zero, writes ignored
// Optional build macro GPIO_IN_BOTH_EDGES_EN: when defined, capture bits set
// on any accepted state change; otherwise only 0->1 changes are captured.
module gpio_switch_input #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int CNT_W           = 15
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw_in,
  input  logic             i_sel,
  input  logic             i_rd,
  input  logic             i_wr,
  input  logic [1:0]       i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_ack,
  output logic             o_irq
);

  // Final count value: when a mismatch is still present here the change is accepted.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_state;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_rdata;
  logic             r_ack;
  logic             r_irq;

  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_capSet;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_capNext;
  logic [WIDTH-1:0] w_readMux;
  logic             w_start;
  logic             w_write;
  logic             w_read;

  // Two-flop synchroniser bringing the asynchronous switch lines into the clock domain.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_sw_in;
      r_sync2 <= r_sync1;
    end
  end

  // A bit is accepted when its synchronised value has disagreed with the state for the full debounce window.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = (r_sync2[i] != r_state[i]) && (r_cnt[i] == LP_CNT_LAST);
    end
  end

  // Per-bit debounce: count consecutive mismatching cycles, any agreement restarts the window.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_state[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_state[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef GPIO_IN_BOTH_EDGES_EN
  assign w_capSet = w_accept;
`else
  assign w_capSet = w_accept & r_sync2;
`endif

  // Bus decode: a new access may only start while no acknowledge is pending,
  // which yields the mandatory idle cycle between back-to-back accesses.
  assign w_start   = i_sel & (i_rd | i_wr) & ~r_ack;
  assign w_write   = w_start & i_wr;
  assign w_read    = w_start & i_rd & ~i_wr;
  assign w_w1c     = (w_write && (i_addr == 2'd1)) ? i_wdata : '0;
  assign w_capNext = (r_cap & ~w_w1c) | w_capSet;

  // Register read multiplexer, sampled on the edge that starts the access.
  always_comb begin
    w_readMux = '0;
    case (i_addr)
      2'd0:    w_readMux = r_state;
      2'd1:    w_readMux = r_cap;
      2'd2:    w_readMux = r_mask;
      default: w_readMux = '0;
    endcase
  end

  // Capture, mask and interrupt registers; irq follows cap&mask one clock later.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cap  <= '0;
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_cap <= w_capNext;
      if (w_write && (i_addr == 2'd2)) begin
        r_mask <= i_wdata;
      end
      r_irq <= |(r_cap & r_mask);
    end
  end

  // Acknowledge and read data: one-cycle ack, rdata is zero unless a pure read completes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_start;
      r_rdata <= w_read ? w_readMux : '0;
    end
  end

  assign o_rdata = r_rdata;
  assign o_ack   = r_ack;
  assign o_irq   = r_irq;

endmodule

// File: tb/tb_gpio_switch_input.sv
// tb_gpio_switch_input
// Directed scenarios followed by randomized traffic for gpio_switch_input
// (WIDTH=8, DEBOUNCE_CYCLES=4). A behavioural reference model tracks the
// expected ack/rdata/irq every clock; directed reads compare against
// hand-derived register values.
module tb_gpio_switch_input;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;

`ifdef GPIO_IN_BOTH_EDGES_EN
  localparam bit BOTH_EDGES = 1'b1;
`else
  localparam bit BOTH_EDGES = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] swIn = '0;
  logic             sel = 1'b0;
  logic             rd = 1'b0;
  logic             wr = 1'b0;
  logic [1:0]       addr = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] rdata;
  logic             ack;
  logic             irq;

  int testCount = 0;
  int failCount = 0;
  bit monEn = 1'b0;

  gpio_switch_input #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_sw_in(swIn),
    .i_sel(sel),
    .i_rd(rd),
    .i_wr(wr),
    .i_addr(addr),
    .i_wdata(wdata),
    .o_rdata(rdata),
    .o_ack(ack),
    .o_irq(irq)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [7:0] mState, mCap, mMask, mRdata;
  logic       mAck, mIrq;
  logic [7:0] swHist[$];
  logic [7:0] syncHist[$];

  // Behavioural model: an input value reaches the debouncer two clocks after it is
  // sampled, and a bit flips once its last DEB synchronised samples all disagree.
  always @(posedge clk or posedge rst) begin : refModel
    logic [7:0] syncNow, setBits, w1cBits, readVal, newState, past;
    logic start, isWrite, isRead, stable;
    if (rst) begin
      mState = '0; mCap = '0; mMask = '0; mRdata = '0;
      mAck = 1'b0; mIrq = 1'b0;
      swHist.delete();
      syncHist.delete();
    end else begin
      syncNow = (swHist.size() >= 2) ? swHist[swHist.size()-2] : 8'h00;
      syncHist.push_back(syncNow);
      if (syncHist.size() > 8) void'(syncHist.pop_front());
      newState = mState;
      setBits  = '0;
      for (int b = 0; b < 8; b++) begin
        stable = (syncHist.size() >= DEB);
        for (int j = 0; j < DEB; j++) begin
          if (j < syncHist.size()) begin
            past = syncHist[syncHist.size()-1-j];
            if (past[b] == mState[b]) stable = 1'b0;
          end
        end
        if (stable) begin
          newState[b] = ~mState[b];
          if (BOTH_EDGES || !mState[b]) setBits[b] = 1'b1;
        end
      end
      swHist.push_back(swIn);
      if (swHist.size() > 4) void'(swHist.pop_front());

      start   = sel && (rd || wr) && !mAck;
      isWrite = start && wr;
      isRead  = start && rd && !wr;
      case (addr)
        2'd0:    readVal = mState;
        2'd1:    readVal = mCap;
        2'd2:    readVal = mMask;
        default: readVal = 8'h00;
      endcase
      w1cBits = (isWrite && addr == 2'd1) ? wdata : 8'h00;

      mIrq   = |(mCap & mMask);
      mRdata = isRead ? readVal : 8'h00;
      mAck   = start;
      if (isWrite && addr == 2'd2) mMask = wdata;
      mCap   = (mCap & ~w1cBits) | setBits;
      mState = newState;
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (monEn && !rst) begin
      checkOutput("ack", {31'b0, ack}, {31'b0, mAck});
      checkOutput("rdata", {24'b0, rdata}, {24'b0, mRdata});
      checkOutput("irq", {31'b0, irq}, {31'b0, mIrq});
    end
  end

  // Drive the switch lines and hold them for a number of clocks (called at a negedge).
  task automatic applyStimulus(input logic [7:0] sw, input int cycles);
    swIn = sw;
    repeat (cycles) @(negedge clk);
  endtask

  // One bus access starting at the next edge; returns the acknowledged read data.
  task automatic busAccess(input logic doRd, input logic doWr, input logic [1:0] a,
                           input logic [7:0] d, output logic [7:0] rdv);
    sel = 1'b1; rd = doRd; wr = doWr; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    checkOutput("busAck", {31'b0, ack}, 32'd1);
    rdv = rdata;
    sel = 1'b0; rd = 1'b0; wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic readCheck(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] v;
    busAccess(1'b1, 1'b0, a, 8'h00, v);
    checkOutput(tag, {24'b0, v}, {24'b0, exp});
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] v;
    busAccess(1'b0, 1'b1, a, d, v);
    checkOutput("wrRdataZero", {24'b0, v}, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Ack"}, {31'b0, ack}, 32'd0);
    checkOutput({tag, "Rdata"}, {24'b0, rdata}, 32'd0);
    checkOutput({tag, "Irq"}, {31'b0, irq}, 32'd0);
  endtask

  initial begin
    logic [7:0] dummy;
    $display("[TB] start, both-edges capture = %0d", BOTH_EDGES);
    repeat (3) @(negedge clk);
    checkAllZero("inReset");
    rst = 1'b0;
    monEn = 1'b1;
    @(negedge clk);

    // 1: idle reads after reset
    readCheck("idleState", 2'd0, 8'h00);
    readCheck("idleCap", 2'd1, 8'h00);
    readCheck("idleMask", 2'd2, 8'h00);
    checkOutput("idleIrq", {31'b0, irq}, 32'd0);

    // 2: bit 0 held high long enough to be accepted
    applyStimulus(8'h01, 10);
    readCheck("t2State", 2'd0, 8'h01);
    readCheck("t2Cap", 2'd1, 8'h01);
    checkOutput("t2Irq", {31'b0, irq}, 32'd0);

    // 3: short glitch on bit 1 is rejected, then a real press raises irq
    applyStimulus(8'h03, 3);
    applyStimulus(8'h01, 10);
    readCheck("t3State", 2'd0, 8'h01);
    readCheck("t3Cap", 2'd1, 8'h01);
    writeReg(2'd2, 8'h02);
    applyStimulus(8'h03, 10);
    checkOutput("t3Irq", {31'b0, irq}, 32'd1);
    readCheck("t3Cap2", 2'd1, 8'h03);

    // 4: W1C lands on the same edge as a new rising edge on bit 1 (accept at 6th edge)
    applyStimulus(8'h01, 10);
    applyStimulus(8'h03, 5);
    writeReg(2'd1, 8'h02);
    checkOutput("t4IrqHeld", {31'b0, irq}, 32'd1);
    readCheck("t4CapKept", 2'd1, 8'h03);
    writeReg(2'd1, 8'h02);
    checkOutput("t4IrqClr", {31'b0, irq}, 32'd0);
    readCheck("t4CapClr", 2'd1, 8'h01);

    // 5: falling edges are captured only in both-edges builds
    writeReg(2'd1, 8'h01);
    applyStimulus(8'h00, 10);
    readCheck("t5Cap", 2'd1, BOTH_EDGES ? 8'h03 : 8'h00);
    readCheck("t5State", 2'd0, 8'h00);

    // 6: reset mid-count, during a pending ack and with irq pending
    writeReg(2'd2, 8'hFF);
    applyStimulus(8'hFF, 10);
    checkOutput("t6IrqPend", {31'b0, irq}, 32'd1);
    applyStimulus(8'h00, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 checkAllZero("rstMidCount");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    readCheck("t6StateAfterRst", 2'd0, 8'h00);
    readCheck("t6MaskAfterRst", 2'd2, 8'h00);

    sel = 1'b1; rd = 1'b0; wr = 1'b1; addr = 2'd2; wdata = 8'hAA;
    @(posedge clk); #1;
    checkOutput("t6AckBeforeRst", {31'b0, ack}, 32'd1);
    rst = 1'b1;
    #1 checkAllZero("rstPendingAck");
    @(negedge clk);
    sel = 1'b0; wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    readCheck("t6MaskCleared", 2'd2, 8'h00);

    writeReg(2'd0, 8'hFF);
    readCheck("t6StateRO", 2'd0, 8'h00);
    writeReg(2'd3, 8'h55);
    readCheck("t6Addr3", 2'd3, 8'h00);

    // input already high when reset is released behaves like a rising edge
    rst = 1'b1;
    swIn = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'hFF, 10);
    readCheck("hiAtRelState", 2'd0, 8'hFF);
    readCheck("hiAtRelCap", 2'd1, 8'hFF);

    // read and write together counts as a write with zero read data
    busAccess(1'b1, 1'b1, 2'd2, 8'h3C, dummy);
    checkOutput("rdWrRdata", {24'b0, dummy}, 32'd0);
    readCheck("rdWrMask", 2'd2, 8'h3C);

    // randomized traffic, checked every clock by the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) swIn = swIn ^ 8'($urandom);
      sel   = ($urandom_range(0, 3) != 0);
      rd    = 1'($urandom);
      wr    = 1'($urandom_range(0, 3) == 0);
      addr  = 2'($urandom);
      wdata = 8'($urandom);
      @(negedge clk);
    end
    sel = 1'b0; rd = 1'b0; wr = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
